// File: rtl/mem_access_unit.sv
// Load/store unit between the EX stage and a simple req/ack memory bus.
// Handles alignment checks, lane enables, store replication, load extension and ack timeout.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: bus_req is held high for the whole REQ state with address,
  // direction, lanes and write data stable; the access completes on the first
  // rising edge where bus_req && bus_ack, and bus_ack is ignored otherwise.

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  wait_cnt;

  logic        accept;
  logic        ack_hit;
  logic        timeout;
  logic        is_word;
  logic        is_half;
  logic        is_store;
  logic        mis_now;
  logic [3:0]  be_now;
  logic [31:0] wd_now;
  logic [31:0] load_val;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  // Request decode on the incoming operation, used only when a start is accepted.
  always_comb begin
    is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
    is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    is_store = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
    mis_now  = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    if (is_word) begin
      be_now = 4'b1111;
      wd_now = wdata;
    end else if (is_half) begin
      be_now = addr[1] ? 4'b1100 : 4'b0011;
      wd_now = {2{wdata[15:0]}};
    end else begin
      be_now = 4'b0001 << addr[1:0];
      wd_now = {4{wdata[7:0]}};
    end
  end

  // Load extraction uses the latched op/offset so late EX-stage changes cannot leak in.
  always_comb begin
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    half_sel = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (addr_lo_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack_hit = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = mis_now ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // An ack in the final wait cycle still completes normally.
        if (bus_req && bus_ack) begin
          ack_hit = 1'b1;
          state_d = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q      <= 3'd0;
      addr_lo_q <= 2'd0;
      wait_cnt  <= 8'd0;
      rdata     <= 32'd0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      if (accept) begin
        op_q      <= mem_op;
        addr_lo_q <= addr[1:0];
        misalign  <= mis_now;
        bus_err   <= 1'b0;
        if (!mis_now) begin
          wait_cnt  <= 8'd0;
          bus_req   <= 1'b1;
          bus_we    <= is_store;
          bus_addr  <= {addr[31:2], 2'b00};
          bus_be    <= be_now;
          bus_wdata <= wd_now;
        end
      end else if (ack_hit) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          rdata <= load_val;
        end
      end else if (state_q == S_REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (timeout) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (MAX_WAIT=4) with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  int          obs_lat;
  int          obs_req_cycles;
  logic        obs_mis;
  logic        obs_err;
  logic        snap_we;
  logic [31:0] snap_addr;
  logic [3:0]  snap_be;
  logic [31:0] snap_wdata;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: issues one op at cycle 0; the ack is driven in cycle 1+k (k<0 means never).
  // With hold_start, start stays high and the request inputs change while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int k, input bit hold_start);
    logic [31:0] exp_rd;
    int c;
    bit first;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    bus_rdata = rd;
    start     = 1'b1;
    cyc();
    if (hold_start) begin
      mem_op = 3'd5;
      addr   = a + 32'h34;
    end else begin
      start = 1'b0;
    end
    c = 1;
    first = 1'b1;
    obs_req_cycles = 0;
    while (!done && c < 40) begin
      if (bus_req) begin
        obs_req_cycles++;
        if (first) begin
          snap_we    = bus_we;
          snap_addr  = bus_addr;
          snap_be    = bus_be;
          snap_wdata = bus_wdata;
          first      = 1'b0;
        end
      end
      bus_ack = (k >= 0) && (c == 1 + k);
      cyc();
      bus_ack = 1'b0;
      c++;
    end
    obs_lat = c;
    check("done_seen", {31'd0, done}, 32'd1);
    obs_mis = misalign;
    obs_err = bus_err;
    exp_rd = exp_q.pop_front();
    check("rdata", rdata, exp_rd);
    start = 1'b0;
    cyc();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; mem_op = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
    check("rst_req", {30'd0, bus_req, bus_we}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", {28'd0, bus_be}, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    cyc();
    rstn = 1'b1;

    // LB at 0x1003, ack in the first REQ cycle
    exp_q.push_back(32'hFFFFFF80);
    run_op(3'd3, 32'h0000_1003, 32'd0, 32'h80AABBCC, 0, 1'b0);
    check("lb_lat", obs_lat, 32'd2);
    check("lb_addr", snap_addr, 32'h0000_1000);
    check("lb_be", {28'd0, snap_be}, 32'h8);
    check("lb_we", {31'd0, snap_we}, 32'd0);
    check("lb_reqcyc", obs_req_cycles, 32'd1);

    // SH at 0x2002, ack after 3 wait cycles (lands on the last allowed cycle)
    exp_q.push_back(32'hFFFFFF80);
    run_op(3'd6, 32'h0000_2002, 32'h1234ABCD, 32'h5555_5555, 3, 1'b0);
    check("sh_lat", obs_lat, 32'd5);
    check("sh_we", {31'd0, snap_we}, 32'd1);
    check("sh_be", {28'd0, snap_be}, 32'hC);
    check("sh_wdata", snap_wdata, 32'hABCDABCD);
    check("sh_err", {31'd0, obs_err}, 32'd0);
    check("sh_reqcyc", obs_req_cycles, 32'd4);

    // LW misaligned
    exp_q.push_back(32'hFFFFFF80);
    run_op(3'd0, 32'h0000_0006, 32'd0, 32'h1111_1111, 0, 1'b0);
    check("lwmis_lat", obs_lat, 32'd1);
    check("lwmis_flag", {31'd0, obs_mis}, 32'd1);
    check("lwmis_noreq", obs_req_cycles, 32'd0);

    // LHU timeout with start held high while busy
    exp_q.push_back(32'hFFFFFF80);
    run_op(3'd2, 32'h0000_0010, 32'd0, 32'h2222_2222, -1, 1'b1);
    check("to_reqcyc", obs_req_cycles, 32'd4);
    check("to_lat", obs_lat, 32'd5);
    check("to_err", {31'd0, obs_err}, 32'd1);
    check("to_mis", {31'd0, obs_mis}, 32'd0);
    check("to_addr", snap_addr, 32'h0000_0010);
    check("to_be", {28'd0, snap_be}, 32'h3);
    check("to_we", {31'd0, snap_we}, 32'd0);
    check("to_err_hold", {31'd0, bus_err}, 32'd1);

    // LW aligned, ack after one wait cycle; clears the previous error
    exp_q.push_back(32'h12345678);
    run_op(3'd0, 32'h0000_0100, 32'd0, 32'h12345678, 1, 1'b0);
    check("lw_lat", obs_lat, 32'd3);
    check("lw_err_clr", {31'd0, obs_err}, 32'd0);

    // LH upper half, sign-extended
    exp_q.push_back(32'hFFFF8001);
    run_op(3'd1, 32'h0000_0102, 32'd0, 32'h80017FFF, 0, 1'b0);
    check("lh_be", {28'd0, snap_be}, 32'hC);

    // SB at offset 3: byte never misaligned, replicated data
    exp_q.push_back(32'hFFFF8001);
    run_op(3'd7, 32'h0000_0003, 32'h0000_00A5, 32'd0, 2, 1'b0);
    check("sb_lat", obs_lat, 32'd4);
    check("sb_be", {28'd0, snap_be}, 32'h8);
    check("sb_wdata", snap_wdata, 32'hA5A5A5A5);
    check("sb_mis", {31'd0, obs_mis}, 32'd0);

    // SW full word
    exp_q.push_back(32'hFFFF8001);
    run_op(3'd5, 32'h0000_0008, 32'hDEADBEEF, 32'd0, 0, 1'b0);
    check("sw_be", {28'd0, snap_be}, 32'hF);
    check("sw_wdata", snap_wdata, 32'hDEADBEEF);

    // LH with odd address is misaligned
    exp_q.push_back(32'hFFFF8001);
    run_op(3'd1, 32'h0000_0005, 32'd0, 32'd0, 0, 1'b0);
    check("lhmis_flag", {31'd0, obs_mis}, 32'd1);
    check("lhmis_noreq", obs_req_cycles, 32'd0);

    // Stray ack while idle has no effect
    bus_ack = 1'b1;
    cyc();
    cyc();
    check("stray_done", {31'd0, done}, 32'd0);
    check("stray_busy", {31'd0, busy}, 32'd0);
    bus_ack = 1'b0;

    // Reset during REQ
    mem_op = 3'd0; addr = 32'h0000_0020; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("pre_rst_req", {31'd0, bus_req}, 32'd1);
    rstn = 1'b0;
    #1;
    check("async_req", {31'd0, bus_req}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_nodone", {31'd0, done}, 32'd0);
    end
    rstn = 1'b1;
    exp_q.push_back(32'h000000F0);
    run_op(3'd4, 32'h0000_0001, 32'd0, 32'h0000F000, 0, 1'b0);
    check("lbu_lat", obs_lat, 32'd2);
    check("lbu_be", {28'd0, snap_be}, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
